// File: rtl/sma_job_pkg.sv
// sma_job_pkg: shared types and register-map constants for the SMA job controller.
// Contents: per-channel state enum, register word/bit positions, local-bus geometry.
package sma_job_pkg;

    // Per-channel job state
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        ACTIVE   = 2'd2
    } ch_state_e;

    // Local-bus geometry
    localparam int unsigned REG_WORDS  = 32;
    localparam int unsigned REG_WORD_W = 64;
    localparam int unsigned REG_BYTES  = REG_WORDS * (REG_WORD_W / 8);

    // Register map
    localparam int unsigned CTRL_WORD       = 0;
    localparam int unsigned CLR_BIT         = 1;
    localparam int unsigned START_BIT_BASE  = 2;
    localparam int unsigned ADDR_WORD_BASE  = 1;
    localparam int unsigned STICKY_BIT_BASE = 32;
    localparam int unsigned CNT_WORD_BASE   = 1;

endpackage

// File: rtl/sma_job_ctrl_if.sv
// sma_job_ctrl_if: local-bus register port plus SMA-side run/req/address signals.
//   reg_in/reg_wr/reg_out : 64-bit write data, 256 byte enables, 32 x 64-bit readback
//   ch_req/run            : per-channel SMA request input and start strobe
//   ral/rah/wal/wah       : per-channel address windows, channel c at [c*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   irq                   : one-cycle completion pulse
// slave = controller side, master = bus/SMA side.
interface sma_job_ctrl_if #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned ADDRESS_WIDTH = 32
);
    logic [63:0]                     reg_in;
    logic [255:0]                    reg_wr;
    logic [2047:0]                   reg_out;
    logic [NUM_CH-1:0]               ch_req;
    logic [NUM_CH-1:0]               run;
    logic [NUM_CH*ADDRESS_WIDTH-1:0] ral;
    logic [NUM_CH*ADDRESS_WIDTH-1:0] rah;
    logic [NUM_CH*ADDRESS_WIDTH-1:0] wal;
    logic [NUM_CH*ADDRESS_WIDTH-1:0] wah;
    logic                            irq;

    modport slave (
        input  reg_in, reg_wr, ch_req,
        output reg_out, run, ral, rah, wal, wah, irq
    );

    modport master (
        output reg_in, reg_wr, ch_req,
        input  reg_out, run, ral, rah, wal, wah, irq
    );
endinterface

// File: rtl/sma_job_ch.sv
// sma_job_ch: one SMA channel -- job FSM, run strobe, address registers,
// done_sticky flag and (with SMA_JOB_CYCLE_CNT_EN) a saturating job cycle counter.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : edge-detected start request
//   clr_sticky         : clear done_sticky
//   ch_req             : SMA req
//   wr_ral..wr_wah     : address register write enables, wr_lo/wr_hi data
//   run                : registered one-cycle start strobe
//   ral, rah, wal, wah : address windows
//   done_sticky        : job completed since last start/clear
//   busy_c             : FSM not IDLE
//   busy_nxt_c         : FSM will not be IDLE next cycle
//   done_set_c         : job finishing this cycle
//   cnt                : job cycle count (SMA_JOB_CYCLE_CNT_EN only)
module sma_job_ch
    import sma_job_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32
`ifdef SMA_JOB_CYCLE_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH = 32
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clr_sticky,
    input  logic                     ch_req,
    input  logic                     wr_ral,
    input  logic                     wr_rah,
    input  logic                     wr_wal,
    input  logic                     wr_wah,
    input  logic [ADDRESS_WIDTH-1:0] wr_lo,
    input  logic [ADDRESS_WIDTH-1:0] wr_hi,
    output logic                     run,
    output logic [ADDRESS_WIDTH-1:0] ral,
    output logic [ADDRESS_WIDTH-1:0] rah,
    output logic [ADDRESS_WIDTH-1:0] wal,
    output logic [ADDRESS_WIDTH-1:0] wah,
    output logic                     done_sticky,
    output logic                     busy_c,
    output logic                     busy_nxt_c,
    output logic                     done_set_c
`ifdef SMA_JOB_CYCLE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     cnt
`endif
);

    ch_state_e state_q;
    ch_state_e state_d;
    logic      run_d;
    logic      start_acc_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; starts outside IDLE are dropped
    always_comb begin
        state_d     = state_q;
        run_d       = 1'b0;
        start_acc_c = 1'b0;
        done_set_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WAIT_REQ;
                    run_d       = 1'b1;
                    start_acc_c = 1'b1;
                end
            end
            WAIT_REQ: begin
                if (ch_req) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!ch_req) begin
                    state_d    = IDLE;
                    done_set_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_c     = (state_q != IDLE);
    assign busy_nxt_c = (state_d != IDLE);

    // Run strobe and completion flag; completion wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            run         <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            run <= run_d;
            if (done_set_c) begin
                done_sticky <= 1'b1;
            end else if (start_acc_c || clr_sticky) begin
                done_sticky <= 1'b0;
            end
        end
    end

    // Address window, writable only while the channel is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            ral <= '0;
            rah <= '0;
            wal <= '0;
            wah <= '0;
        end else if (state_q == IDLE) begin
            if (wr_ral) ral <= wr_lo;
            if (wr_rah) rah <= wr_hi;
            if (wr_wal) wal <= wr_lo;
            if (wr_wah) wah <= wr_hi;
        end
    end

`ifdef SMA_JOB_CYCLE_CNT_EN
    // Job length counter: cleared on start, saturating, frozen once idle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start_acc_c) begin
            cnt <= '0;
        end else if (busy_c && (cnt != {CNT_WIDTH{1'b1}})) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: rtl/sma_job_ctrl.sv
// sma_job_ctrl: register-mapped job controller for NUM_CH SMA channels.
// Decodes the control word and address writes, instantiates one sma_job_ch per
// channel, aggregates busy/done status into readback word 0 and raises irq.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sma_job_ctrl_if.slave (reg_in, reg_wr, reg_out, ch_req, run,
//              ral, rah, wal, wah, irq)
// Optional: define SMA_JOB_CYCLE_CNT_EN for per-job cycle counters in words 1+c.
module sma_job_ctrl
    import sma_job_pkg::*;
#(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic          clk,
    input  logic          rst,
    sma_job_ctrl_if.slave bus
);

    localparam int unsigned REG_OUT_W = REG_WORDS * REG_WORD_W;

    if (NUM_CH < 1 || NUM_CH > 15) begin : g_bad_num_ch
        $error("sma_job_ctrl: NUM_CH must be 1..15");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > 64) begin : g_bad_cnt_width
        $error("sma_job_ctrl: CNT_WIDTH must be 1..64");
    end

    logic                     wr_ctrl;
    logic                     clr_c;
    logic [NUM_CH-1:0]        start_raw;
    logic [NUM_CH-1:0]        start_raw_q;
    logic [NUM_CH-1:0]        start_pulse;
    logic [ADDRESS_WIDTH-1:0] addr_lo;
    logic [ADDRESS_WIDTH-1:0] addr_hi;

    logic [NUM_CH-1:0]               run_w;
    logic [NUM_CH*ADDRESS_WIDTH-1:0] ral_w;
    logic [NUM_CH*ADDRESS_WIDTH-1:0] rah_w;
    logic [NUM_CH*ADDRESS_WIDTH-1:0] wal_w;
    logic [NUM_CH*ADDRESS_WIDTH-1:0] wah_w;
    logic [NUM_CH-1:0]               done_sticky;
    logic [NUM_CH-1:0]               busy;
    logic [NUM_CH-1:0]               busy_nxt;
    logic [NUM_CH-1:0]               done_set;
`ifdef SMA_JOB_CYCLE_CNT_EN
    logic [CNT_WIDTH-1:0]            cnt [NUM_CH];
`endif

    logic                 busy_any;
    logic                 done_all;
    logic                 irq_q;
    logic [REG_OUT_W-1:0] reg_out_c;
    logic                 unused_bus_bits;

    // Control-word decode; a start held across write cycles counts once
    assign wr_ctrl     = bus.reg_wr[8*CTRL_WORD];
    assign clr_c       = wr_ctrl & bus.reg_in[CLR_BIT];
    assign start_raw   = bus.reg_in[START_BIT_BASE +: NUM_CH] & {NUM_CH{wr_ctrl}};
    assign start_pulse = start_raw & ~start_raw_q;
    assign addr_lo     = ADDRESS_WIDTH'(bus.reg_in[31:0]);
    assign addr_hi     = ADDRESS_WIDTH'(bus.reg_in[63:32]);

    always_ff @(posedge clk) begin
        if (rst) begin
            start_raw_q <= '0;
        end else begin
            start_raw_q <= start_raw;
        end
    end

    // Channel c: ral/rah in word 1+2c (low/high half), wal/wah in word 2+2c
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int unsigned RD_BYTE = 8 * (ADDR_WORD_BASE + 2 * c);
        localparam int unsigned WR_BYTE = 8 * (ADDR_WORD_BASE + 2 * c + 1);

        sma_job_ch #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
`ifdef SMA_JOB_CYCLE_CNT_EN
            ,
            .CNT_WIDTH     (CNT_WIDTH)
`endif
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .start       (start_pulse[c]),
            .clr_sticky  (clr_c),
            .ch_req      (bus.ch_req[c]),
            .wr_ral      (bus.reg_wr[RD_BYTE]),
            .wr_rah      (bus.reg_wr[RD_BYTE + 4]),
            .wr_wal      (bus.reg_wr[WR_BYTE]),
            .wr_wah      (bus.reg_wr[WR_BYTE + 4]),
            .wr_lo       (addr_lo),
            .wr_hi       (addr_hi),
            .run         (run_w[c]),
            .ral         (ral_w[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .rah         (rah_w[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .wal         (wal_w[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .wah         (wah_w[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .done_sticky (done_sticky[c]),
            .busy_c      (busy[c]),
            .busy_nxt_c  (busy_nxt[c]),
            .done_set_c  (done_set[c])
`ifdef SMA_JOB_CYCLE_CNT_EN
            ,
            .cnt         (cnt[c])
`endif
        );
    end

    assign busy_any = |busy;
    assign done_all = (|done_sticky) & ~busy_any;

    // Completion interrupt: last busy channel finishing this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= busy_any & ~(|busy_nxt) & (|done_set);
        end
    end

    // Readback: live status in word 0, optional counters in words 1+c
    always_comb begin
        reg_out_c                                = '0;
        reg_out_c[0]                             = done_all;
        reg_out_c[1]                             = busy_any;
        reg_out_c[START_BIT_BASE +: NUM_CH]      = bus.ch_req;
        reg_out_c[STICKY_BIT_BASE +: NUM_CH]     = done_sticky;
`ifdef SMA_JOB_CYCLE_CNT_EN
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            reg_out_c[(CNT_WORD_BASE + c)*REG_WORD_W +: REG_WORD_W] = REG_WORD_W'(cnt[c]);
        end
`endif
    end

    // Byte enables outside the decoded map carry no function
    assign unused_bus_bits = ^{bus.reg_wr, bus.reg_in};

    assign bus.reg_out = reg_out_c;
    assign bus.run     = run_w;
    assign bus.ral     = ral_w;
    assign bus.rah     = rah_w;
    assign bus.wal     = wal_w;
    assign bus.wah     = wah_w;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_sma_job_ctrl.sv
// tb_sma_job_ctrl: directed self-checking bench for sma_job_ctrl with NUM_CH=4.
module tb_sma_job_ctrl;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sma_job_ctrl_if #(.NUM_CH(NCH), .ADDRESS_WIDTH(AW)) bus ();

    sma_job_ctrl #(
        .NUM_CH        (NCH),
        .ADDRESS_WIDTH (AW),
        .CNT_WIDTH     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] din;
        logic        wr0;
        logic [3:0]  req;
        logic [3:0]  exp_run;
        logic        exp_irq;
        logic [63:0] exp_w0;
    } vec_t;

    vec_t vecs [13];
    int   irq_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word(input int unsigned k);
        return bus.reg_out[k*64 +: 64];
    endfunction

    task automatic idle_bus();
        bus.reg_in = '0;
        bus.reg_wr = '0;
    endtask

    task automatic do_reset();
        idle_bus();
        bus.ch_req = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic ctrl_write(input logic [63:0] d);
        bus.reg_in    = d;
        bus.reg_wr    = '0;
        bus.reg_wr[0] = 1'b1;
    endtask

    initial begin
        // ch1 job, then a held start of ch0, then clear
        vecs[0]  = '{64'h0, 1'b0, 4'b0000, 4'b0000, 1'b0, 64'h0};
        vecs[1]  = '{64'h8, 1'b1, 4'b0000, 4'b0010, 1'b0, 64'h2};
        vecs[2]  = '{64'h8, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h2};
        vecs[3]  = '{64'h0, 1'b0, 4'b0010, 4'b0000, 1'b0, 64'hA};
        vecs[4]  = '{64'h0, 1'b0, 4'b0010, 4'b0000, 1'b0, 64'hA};
        vecs[5]  = '{64'h0, 1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0000_0002_0000_0001};
        vecs[6]  = '{64'h0, 1'b0, 4'b0000, 4'b0000, 1'b0, 64'h0000_0002_0000_0001};
        vecs[7]  = '{64'h4, 1'b1, 4'b0000, 4'b0001, 1'b0, 64'h0000_0002_0000_0002};
        vecs[8]  = '{64'h4, 1'b1, 4'b0001, 4'b0000, 1'b0, 64'h0000_0002_0000_0006};
        vecs[9]  = '{64'h4, 1'b1, 4'b0000, 4'b0000, 1'b1, 64'h0000_0003_0000_0001};
        vecs[10] = '{64'h4, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0000_0003_0000_0001};
        vecs[11] = '{64'h0, 1'b0, 4'b0000, 4'b0000, 1'b0, 64'h0000_0003_0000_0001};
        vecs[12] = '{64'h2, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0};

        do_reset();
        check("reset_word0", 128'(word(0)), 128'h0);
        check("reset_run",   128'(bus.run), 128'h0);
        check("reset_irq",   128'(bus.irq), 128'h0);
        check("reset_ral",   128'(bus.ral), 128'h0);

        for (int i = 0; i < 13; i++) begin
            bus.reg_in    = vecs[i].din;
            bus.reg_wr    = '0;
            bus.reg_wr[0] = vecs[i].wr0;
            bus.ch_req    = vecs[i].req;
            step();
            check($sformatf("vec%0d_run", i), 128'(bus.run), 128'(vecs[i].exp_run));
            check($sformatf("vec%0d_irq", i), 128'(bus.irq), 128'(vecs[i].exp_irq));
            check($sformatf("vec%0d_w0", i),  128'(word(0)), 128'(vecs[i].exp_w0));
        end

        // Address writes to channel 2 only
        do_reset();
        bus.reg_in     = {32'h0000_ABCD, 32'h0000_1000};
        bus.reg_wr     = '0;
        bus.reg_wr[40] = 1'b1;
        bus.reg_wr[52] = 1'b1;
        step();
        idle_bus();
        check("ral2", 128'(bus.ral), {32'h0, 32'h0, 32'h0000_1000, 64'h0});
        check("wah2", 128'(bus.wah), {32'h0, 32'h0000_ABCD, 64'h0});
        check("rah_untouched", 128'(bus.rah), 128'h0);
        check("wal_untouched", 128'(bus.wal), 128'h0);

        // ch0 and ch3 together, ch0 finishing 5 cycles earlier
        do_reset();
        irq_cnt = 0;
        ctrl_write(64'h24);
        step();
        check("dual_run", 128'(bus.run), 128'b1001);
        idle_bus();
        bus.ch_req = 4'b1001;
        step();
        bus.ch_req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.irq) irq_cnt++;
        end
        check("dual_busy_mid", 128'(word(0) & 64'h3), 128'h2);
        bus.ch_req = 4'b0000;
        step();
        check("dual_irq_last", 128'(bus.irq), 128'h1);
        if (bus.irq) irq_cnt++;
        check("dual_sticky", 128'(word(0)), 128'h0000_0009_0000_0001);
        step();
        if (bus.irq) irq_cnt++;
        check("dual_irq_count", 128'(irq_cnt), 128'h1);

        // Restart and address write while ch1 is active are ignored
        do_reset();
        bus.reg_in     = 64'h55;
        bus.reg_wr     = '0;
        bus.reg_wr[24] = 1'b1;
        step();
        check("ral1_idle_write", 128'(bus.ral), 128'h55_0000_0000);
        ctrl_write(64'h8);
        step();
        idle_bus();
        bus.ch_req = 4'b0010;
        step();
        bus.reg_in     = 64'h0000_0000_DEAD_0008;
        bus.reg_wr     = '0;
        bus.reg_wr[0]  = 1'b1;
        bus.reg_wr[24] = 1'b1;
        step();
        idle_bus();
        check("restart_no_run", 128'(bus.run), 128'h0);
        check("ral1_protected", 128'(bus.ral), 128'h55_0000_0000);
        bus.ch_req = 4'b0000;
        step();
        check("restart_irq", 128'(bus.irq), 128'h1);

        // Start ch0 together with clear while sticky = 0110
        do_reset();
        ctrl_write(64'h18);
        step();
        idle_bus();
        bus.ch_req = 4'b0110;
        step();
        bus.ch_req = 4'b0000;
        step();
        step();
        check("pre_clear_sticky", 128'(word(0)), 128'h0000_0006_0000_0001);
        ctrl_write(64'h6);
        step();
        idle_bus();
        check("start_clr_run", 128'(bus.run), 128'b0001);
        check("start_clr_w0",  128'(word(0)), 128'h2);
        step();
        check("start_clr_run_once", 128'(bus.run), 128'h0);

        // Reset during an active ch2 job
        do_reset();
        ctrl_write(64'h10);
        step();
        idle_bus();
        bus.ch_req = 4'b0100;
        step();
        check("pre_rst_busy", 128'(word(0)), 128'h12);
        rst = 1'b1;
        bus.ch_req = 4'b0000;
        step();
        check("rst_w0",  128'(word(0)), 128'h0);
        check("rst_irq", 128'(bus.irq), 128'h0);
        check("rst_run", 128'(bus.run), 128'h0);
        rst = 1'b0;
        step();
        check("post_rst_irq", 128'(bus.irq), 128'h0);
        check("post_rst_w0",  128'(word(0)), 128'h0);

        // ch2 job: 3 cycles waiting for req, 7 cycles active
        do_reset();
        ctrl_write(64'h10);
        step();
        idle_bus();
        step();
        step();
        bus.ch_req = 4'b0100;
        step();
        for (int i = 0; i < 6; i++) step();
        bus.ch_req = 4'b0000;
        step();
        step();
        step();
`ifdef SMA_JOB_CYCLE_CNT_EN
        check("cnt_ch2", 128'(word(3)), 128'd10);
`else
        check("cnt_ch2_absent", 128'(word(3)), 128'd0);
`endif
        begin
            logic [63:0] others;
            others = '0;
            for (int k = 1; k < 32; k++) begin
                if (k != 3) others |= word(k);
            end
            check("other_words_zero", 128'(others), 128'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
